player_ctrl: RTL and testbench
==============================

Name: player_ctrl

Overview:
Position controller for one paddle, directly upstream of the paddle-draw stage: produces the 10-bit `pos` that stage consumes.
- Samples two push-buttons once per video frame.
- Runs a small direction FSM and moves the paddle with a clamped, optionally accelerating step.
- Frame timing comes from the same 26-bit RGB stream the draw stage receives, so `pos` changes only at frame start and never tears mid-frame.

Parameters:
- pos_limit, 600: screen extent along the paddle's travel axis, in pixels (600 vertical, 800 horizontal).
- size_player, 80: paddle length in pixels; must match the draw stage.
- pos_init, 260: position after reset; must be <= pos_limit - size_player.
- step_min, 2: pixels moved per frame on the first frame of a press.
- step_max, 8: ceiling for the per-frame step (used only with acceleration).

Ports:
- px_clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low (one clock; asserted asynchronously and released synchronously by the board top).
- strRGB_i  in  26  RGB stream; only bit 1 (VS) is used.
- btn_up  in  1  raw, asynchronous button; decreases pos.
- btn_down  in  1  raw, asynchronous button; increases pos.
- pos  out  10  paddle position, to the draw stage's pos input.
- moving  out  1  high while FSM is in UP or DOWN.
- at_limit  out  1  high when pos == 0 or pos == pos_limit - size_player.

Behaviour:
- Reset values (rst_n low, immediate): pos = pos_init, moving = 0, at_limit = 0 (1 if pos_init is at a limit), FSM = IDLE, spd = step_min, both synchroniser chains = 0, vs_d = 0.
- Button sync: each button passes through a 2-flop synchroniser. No other debounce is applied; per-frame sampling (about 60 Hz) is the debounce.
- Frame tick:
  - vs_d registers strRGB_i[1].
  - tick = strRGB_i[1] & ~vs_d, a single-cycle pulse on each VS rising edge.
  - Every state and output update below happens only in the cycle tick is high. Between ticks all registers hold.
- FSM states IDLE, UP, DOWN. Next state at tick, from the synchronised buttons:
  - up only -> UP
  - down only -> DOWN
  - neither, or both -> IDLE
  - UP <-> DOWN is a direct transition; it does not pass through IDLE.
- Step selection at tick:
  - step = step_min if next state differs from current state, otherwise spd.
  - spd <= min(step+1, step_max) when next is UP/DOWN; spd <= step_min when next is IDLE.
- Position update at tick, computed in 11-bit unsigned:
  - UP: pos <= (pos < step) ? 0 : pos - step.
  - DOWN: pos <= (pos + step > pos_max) ? pos_max : pos + step, where pos_max = pos_limit - size_player.
  - IDLE: pos unchanged.
  - pos never leaves [0, pos_max]. There is no wrap-around.
- Outputs:
  - pos, moving and at_limit are all registered and update in the cycle after tick.
  - Latency is 1 px_clk from the VS edge.
  - moving reflects the FSM state; at_limit is computed from the new pos.
- Holding a button against a limit: pos stays pinned, moving stays 1, at_limit stays 1, and spd keeps saturating.
- rst_n asserted mid-frame or mid-press: immediate return to reset values. The first tick after release acts from IDLE with spd = step_min.
- No tick while rst_n is low: vs_d is held at 0. If VS is already high at release, tick fires on the first clock, which is acceptable.

Optional Feature:
- PLAYER_ACCEL_EN defined: spd ramps as above, one pixel per held frame, up to step_max.
- PLAYER_ACCEL_EN not defined:
  - step is always step_min.
  - The spd register and step_max logic are removed.
  - step_max is ignored.

Decomposition:
- Shared package pong_pkg holds:
  - the stream bit-field positions (Active 0, VS 1, HS 2, YC 12:3, XC 22:13, RGB 25:23), replacing per-file defines;
  - screen constants 800/600;
  - the paddle size constant 80;
  - the FSM state typedef {IDLE, UP, DOWN}.
- One sub-module, sync_2ff (parameterised width, async active-low reset), is instantiated once for the 2-bit button vector and is reusable by the second player and the ball controller.

Test Plan:
- Reset, then hold btn_down for 5 frames, accel on (step_min 2, step_max 8) -> pos 260→262→265→269→274→280 (steps 2,3,4,5,6); moving = 1.
- Feature off, same stimulus -> pos 262, 264, 266, 268, 270.
- pos driven to 5 by pressing btn_up, keep holding -> next tick pos = 0, at_limit = 1, following ticks pos stays 0.
- Press both buttons from UP state -> FSM IDLE, pos unchanged, moving = 0, spd back to 2.
- Hold down for 3 frames (pos 269), switch to up -> first step is 2 (pos 267), not 5.
- Assert rst_n mid-line while pos = 400 and VS toggling; also toggle buttons between VS edges without a VS edge -> pos = 260 immediately on reset; no pos change occurs without a VS rising edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the pong video pipeline: stream bit-fields, screen and
// paddle geometry, and the paddle direction FSM state type.
package pong_pkg;

  localparam int STREAM_W   = 26;
  localparam int ACTIVE_BIT = 0;
  localparam int VS_BIT     = 1;
  localparam int HS_BIT     = 2;
  localparam int YC_LSB     = 3;
  localparam int YC_MSB     = 12;
  localparam int XC_LSB     = 13;
  localparam int XC_MSB     = 22;
  localparam int RGB_LSB    = 23;
  localparam int RGB_MSB    = 25;

  localparam int SCREEN_W    = 800;
  localparam int SCREEN_H    = 600;
  localparam int PLAYER_SIZE = 80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } player_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a vector of independent asynchronous inputs.
// Each bit is synchronised on its own; there is no cross-bit coherency.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/player_ctrl.sv
// Paddle position controller: buttons sampled once per frame on the VS rising
// edge, clamped movement. Define PLAYER_ACCEL_EN to ramp the step while held.
module player_ctrl
  import pong_pkg::*;
#(
  parameter int pos_limit   = SCREEN_H,
  parameter int size_player = PLAYER_SIZE,
  parameter int pos_init    = 260,
  parameter int step_min    = 2,
  parameter int step_max    = 8
) (
  input  logic                px_clk,
  input  logic                rst_n,
  input  logic [STREAM_W-1:0] strRGB_i,
  input  logic                btn_up,
  input  logic                btn_down,
  output logic [9:0]          pos,
  output logic                moving,
  output logic                at_limit
);

  localparam logic [10:0] POS_MAX       = 11'(pos_limit - size_player);
  localparam logic [10:0] POS_INIT      = 11'(pos_init);
  localparam logic [10:0] STEP_MIN      = 11'(step_min);
  localparam logic [10:0] STEP_MAX      = 11'(step_max);
  localparam logic        AT_LIMIT_INIT = (POS_INIT == 11'd0) || (POS_INIT == POS_MAX);

  logic [1:0]    w_btn;
  logic          w_tick;
  logic          w_unused;
  player_state_t w_next;
  logic [10:0]   w_pos;
  logic [10:0]   w_step;
  logic [10:0]   w_pos_next;

  logic          r_vs_d;
  player_state_t r_state;
  logic [9:0]    r_pos;
  logic          r_moving;
  logic          r_at_limit;

  sync_2ff #(.WIDTH(2)) u_btn_sync (
    .i_clk   (px_clk),
    .i_rst_n (rst_n),
    .i_d     ({btn_down, btn_up}),
    .o_q     (w_btn)
  );

  assign w_tick   = strRGB_i[VS_BIT] & ~r_vs_d;
  assign w_pos    = {1'b0, r_pos};
  assign w_unused = ^{strRGB_i[STREAM_W-1:VS_BIT+1], strRGB_i[ACTIVE_BIT], STEP_MAX};

  always_comb begin
    w_next = IDLE;
    case (w_btn)
      2'b01:   w_next = UP;
      2'b10:   w_next = DOWN;
      default: w_next = IDLE;
    endcase
  end

`ifdef PLAYER_ACCEL_EN
  logic [10:0] r_spd;
  logic [10:0] w_spd_next;

  always_comb begin
    w_step     = (w_next != r_state) ? STEP_MIN : r_spd;
    w_spd_next = STEP_MIN;
    if (w_next != IDLE)
      w_spd_next = (w_step + 11'd1 > STEP_MAX) ? STEP_MAX : w_step + 11'd1;
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n)
      r_spd <= STEP_MIN;
    else if (w_tick)
      r_spd <= w_spd_next;
  end
`else
  assign w_step = STEP_MIN;
`endif

  // Clamp at both ends instead of wrapping; 11 bits keeps pos + step exact.
  always_comb begin
    w_pos_next = w_pos;
    case (w_next)
      UP:      w_pos_next = (w_pos < w_step) ? 11'd0 : w_pos - w_step;
      DOWN:    w_pos_next = (w_pos + w_step > POS_MAX) ? POS_MAX : w_pos + w_step;
      default: w_pos_next = w_pos;
    endcase
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d     <= 1'b0;
      r_state    <= IDLE;
      r_pos      <= POS_INIT[9:0];
      r_moving   <= 1'b0;
      r_at_limit <= AT_LIMIT_INIT;
    end else begin
      r_vs_d <= strRGB_i[VS_BIT];
      if (w_tick) begin
        r_state    <= w_next;
        r_pos      <= w_pos_next[9:0];
        r_moving   <= (w_next != IDLE);
        r_at_limit <= (w_pos_next == 11'd0) || (w_pos_next == POS_MAX);
      end
    end
  end

  assign pos      = r_pos;
  assign moving   = r_moving;
  assign at_limit = r_at_limit;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: expected paddle state is queued at each VS
// rising edge and compared one clock later.
module tb_player_ctrl;

  localparam int POS_INIT = 260;
  localparam int POS_MAX  = 520;
  localparam int STEP_MIN = 2;
  localparam int STEP_MAX = 8;

  logic        px_clk = 1'b0;
  logic        rst_n;
  logic [25:0] strRGB_i;
  logic        btn_up;
  logic        btn_down;
  logic [9:0]  pos;
  logic        moving;
  logic        at_limit;

  always #5 px_clk = ~px_clk;

  player_ctrl dut (
    .px_clk   (px_clk),
    .rst_n    (rst_n),
    .strRGB_i (strRGB_i),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .pos      (pos),
    .moving   (moving),
    .at_limit (at_limit)
  );

  typedef struct {
    int p;
    int mv;
    int lim;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_pos;
  int   m_dir;
  int   m_spd;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = POS_INIT;
    m_dir = 0;
    m_spd = STEP_MIN;
  endtask

  // Direction codes: 0 idle, 1 up, 2 down.
  task automatic model_tick(input bit up, input bit dn);
    int   nd;
    int   st;
    exp_t e;
    nd = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
`ifdef PLAYER_ACCEL_EN
    st = (nd == m_dir) ? m_spd : STEP_MIN;
`else
    st = STEP_MIN;
`endif
    if (nd == 1) m_pos = (m_pos - st < 0) ? 0 : m_pos - st;
    if (nd == 2) m_pos = (m_pos + st > POS_MAX) ? POS_MAX : m_pos + st;
    m_spd = (nd == 0) ? STEP_MIN : ((st + 1 > STEP_MAX) ? STEP_MAX : st + 1);
    m_dir = nd;
    e.p   = m_pos;
    e.mv  = (nd != 0) ? 1 : 0;
    e.lim = (m_pos == 0 || m_pos == POS_MAX) ? 1 : 0;
    sbq.push_back(e);
  endtask

  task automatic frame(input bit up, input bit dn);
    exp_t e;
    @(negedge px_clk);
    btn_up   = up;
    btn_down = dn;
    strRGB_i[25:2] = 24'($urandom);
    strRGB_i[0]    = 1'($urandom);
    repeat (3) @(negedge px_clk);
    chk("hold_pos", int'(pos), m_pos);
    strRGB_i[1] = 1'b1;
    model_tick(up, dn);
    @(posedge px_clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("pos", int'(pos), e.p);
      chk("moving", int'(moving), e.mv);
      chk("at_limit", int'(at_limit), e.lim);
    end
    repeat (3) @(negedge px_clk);
    strRGB_i[1] = 1'b0;
    chk("single_tick", int'(pos), m_pos);
  endtask

  task automatic do_reset();
    @(negedge px_clk);
    rst_n = 1'b0;
    #1;
    chk("rst_pos", int'(pos), 260);
    chk("rst_moving", int'(moving), 0);
    chk("rst_at_limit", int'(at_limit), 0);
    strRGB_i[1] = 1'b0;
    repeat (2) @(negedge px_clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n    = 1'b0;
    strRGB_i = '0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    model_reset();
    repeat (2) @(negedge px_clk);
    do_reset();

    // Five held frames of down
    for (int i = 0; i < 5; i++) frame(1'b0, 1'b1);
`ifdef PLAYER_ACCEL_EN
    chk("down5_pos", int'(pos), 280);
`else
    chk("down5_pos", int'(pos), 270);
`endif
    chk("down5_moving", int'(moving), 1);

    // Hold up until pinned at zero, then keep holding
    for (int i = 0; i < 200 && m_pos > 0; i++) frame(1'b1, 1'b0);
    chk("top_pos", int'(pos), 0);
    chk("top_limit", int'(at_limit), 1);
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0);
    chk("top_pinned", int'(pos), 0);

    // Hold down until pinned at the far limit
    for (int i = 0; i < 300 && m_pos < POS_MAX; i++) frame(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b1);
    chk("bot_pos", int'(pos), POS_MAX);
    chk("bot_limit", int'(at_limit), 1);

    // Both buttons from UP: idle, then restart at minimum step
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b1);
    chk("both_moving", int'(moving), 0);
    frame(1'b1, 1'b0);

    // Direction reversal restarts at the minimum step
    do_reset();
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b1);
`ifdef PLAYER_ACCEL_EN
    chk("rev_down3", int'(pos), 269);
    frame(1'b1, 1'b0);
    chk("rev_up1", int'(pos), 267);
`else
    chk("rev_down3", int'(pos), 266);
    frame(1'b1, 1'b0);
    chk("rev_up1", int'(pos), 264);
`endif

    // Drive past 400, then reset mid-line with VS toggling
    for (int i = 0; i < 200 && m_pos < 400; i++) frame(1'b0, 1'b1);
    @(negedge px_clk);
    strRGB_i[1] = 1'b1;
    @(negedge px_clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pos", int'(pos), 260);
    chk("mid_rst_moving", int'(moving), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge px_clk);
      strRGB_i[1] = ~strRGB_i[1];
    end
    chk("in_rst_pos", int'(pos), 260);
    @(negedge px_clk);
    strRGB_i[1] = 1'b0;
    rst_n       = 1'b1;
    model_reset();

    // Button activity without a VS edge must not move the paddle
    for (int i = 0; i < 20; i++) begin
      @(negedge px_clk);
      btn_up   = 1'($urandom);
      btn_down = 1'($urandom);
    end
    repeat (3) @(negedge px_clk);
    chk("no_vs_pos", int'(pos), 260);
    chk("no_vs_moving", int'(moving), 0);

    frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    chk("post_rst_step", int'(pos), 262);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
